div_arbiter: RTL and testbench

DIV_ARBITER -- requirements
Module: div_arbiter

---
 rtl/div_pkg.sv | 20 ++
 rtl/div_arbiter_if.sv | 38 +++
 rtl/rr_picker.sv | 39 +++
 rtl/div_arbiter.sv | 141 ++++++++++++++
 tb/tb_div_arbiter.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the divider arbiter slice:
//   DIV_WIDTH    - default operand/result width
//   DIV_NUM_REQ  - default number of requesters
//   arb_state_t  - arbiter FSM state encoding
// -----------------------------------------------------------------------------
package div_pkg;

  localparam int DIV_WIDTH   = 32;
  localparam int DIV_NUM_REQ = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

endpackage

// File: rtl/div_arbiter_if.sv
// -----------------------------------------------------------------------------
// div_arbiter_if
// Requester-side bundle of the divider arbiter.
//   req_valid      - per-requester request, held until req_ready
//   req_dividend   - per-requester dividend
//   req_divisor    - per-requester divisor
//   req_ready      - one-hot accept pulse
//   resp_valid     - one-hot result pulse to the owning requester
//   resp_quotient  - shared quotient bus, valid with resp_valid
//   resp_remainder - shared remainder bus, valid with resp_valid
//   resp_error     - divide-by-zero flag, valid with resp_valid
// Modports: master (requesters), slave (arbiter).
// -----------------------------------------------------------------------------
interface div_arbiter_if import div_pkg::*; #(
  parameter int WIDTH   = DIV_WIDTH,
  parameter int NUM_REQ = DIV_NUM_REQ
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0][WIDTH-1:0] req_dividend;
  logic [NUM_REQ-1:0][WIDTH-1:0] req_divisor;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            resp_valid;
  logic [WIDTH-1:0]              resp_quotient;
  logic [WIDTH-1:0]              resp_remainder;
  logic                          resp_error;

  modport master (
    output req_valid, req_dividend, req_divisor,
    input  req_ready, resp_valid, resp_quotient, resp_remainder, resp_error
  );

  modport slave (
    input  req_valid, req_dividend, req_divisor,
    output req_ready, resp_valid, resp_quotient, resp_remainder, resp_error
  );

endinterface

// File: rtl/rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin selector. Search starts at (i_last+1) mod NUM_REQ.
//   i_req   - request vector
//   i_last  - index of the previous grant
//   o_grant - one-hot grant
//   o_idx   - index of the grant
//   o_valid - at least one request present
// -----------------------------------------------------------------------------
module rr_picker import div_pkg::*; #(
  parameter int NUM_REQ = DIV_NUM_REQ,
  parameter int IDXW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDXW-1:0]    i_last,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDXW-1:0]    o_idx,
  output logic               o_valid
);

  logic [IDXW-1:0] w_cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = '0;
    // Offsets 1..NUM_REQ so the previous winner is considered last.
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      w_cand = IDXW'((32'(i_last) + i) % NUM_REQ);
      if (!o_valid && i_req[w_cand]) begin
        o_valid         = 1'b1;
        o_idx           = w_cand;
        o_grant[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// -----------------------------------------------------------------------------
// div_arbiter
// Shares one divider among NUM_REQ requesters, one transaction in flight.
// Ports:
//   clk, rst           - clock, asynchronous active-high reset
//   req_if (slave)     - requester bundle (request / accept / response)
//   div_dividend       - operand to divider (latched)
//   div_divisor        - operand to divider (latched)
//   div_data_in_valid  - one-cycle start pulse to divider
//   div_quotient       - divider quotient
//   div_remainder      - divider remainder
//   div_data_out_valid - divider result strobe
//   div_error          - divider divide-by-zero flag
//   div_busy           - divider busy, blocks new grants
//   arb_busy           - high whenever the FSM is not IDLE
// Optional feature: define DIV_ARB_ZERO_BYPASS_EN to answer zero-divisor
// requests directly (q=0, r=0, error=1) without using the divider.
// -----------------------------------------------------------------------------
module div_arbiter import div_pkg::*; #(
  parameter int WIDTH   = DIV_WIDTH,
  parameter int NUM_REQ = DIV_NUM_REQ
) (
  input  logic             clk,
  input  logic             rst,
  div_arbiter_if.slave     req_if,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  output logic             div_data_in_valid,
  input  logic [WIDTH-1:0] div_quotient,
  input  logic [WIDTH-1:0] div_remainder,
  input  logic             div_data_out_valid,
  input  logic             div_error,
  input  logic             div_busy,
  output logic             arb_busy
);

  localparam int IDXW = $clog2(NUM_REQ);

  arb_state_t         r_state, w_next;
  logic [IDXW-1:0]    r_last, r_gnt_idx;
  logic [NUM_REQ-1:0] r_gnt_oh, r_req_ready, r_resp_valid;
  logic [WIDTH-1:0]   r_dividend, r_divisor, r_quot, r_rem;
  logic               r_err, r_div_in_valid;

  logic [NUM_REQ-1:0] w_pick_oh;
  logic [IDXW-1:0]    w_pick_idx;
  logic               w_pick_valid, w_grant, w_bypass;
  logic [WIDTH-1:0]   w_sel_dividend, w_sel_divisor;

  rr_picker #(.NUM_REQ(NUM_REQ), .IDXW(IDXW)) u_picker (
    .i_req   (req_if.req_valid),
    .i_last  (r_last),
    .o_grant (w_pick_oh),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  assign w_grant        = (r_state == IDLE) && w_pick_valid && !div_busy;
  assign w_sel_dividend = req_if.req_dividend[w_pick_idx];
  assign w_sel_divisor  = req_if.req_divisor[w_pick_idx];

`ifdef DIV_ARB_ZERO_BYPASS_EN
  assign w_bypass = (w_sel_divisor == '0);
`else
  assign w_bypass = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_grant) w_next = w_bypass ? RESP : ISSUE;
      ISSUE:   w_next = WAIT;
      WAIT:    if (div_data_out_valid) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last         <= IDXW'(NUM_REQ - 1);
      r_gnt_idx      <= '0;
      r_gnt_oh       <= '0;
      r_req_ready    <= '0;
      r_resp_valid   <= '0;
      r_dividend     <= '0;
      r_divisor      <= '0;
      r_quot         <= '0;
      r_rem          <= '0;
      r_err          <= 1'b0;
      r_div_in_valid <= 1'b0;
    end else begin
      r_req_ready    <= '0;
      r_resp_valid   <= '0;
      r_div_in_valid <= 1'b0;
      case (r_state)
        IDLE: if (w_grant) begin
          r_gnt_idx   <= w_pick_idx;
          r_gnt_oh    <= w_pick_oh;
          r_req_ready <= w_pick_oh;
          if (w_bypass) begin
            // Response is produced straight from the grant; the divider
            // pins keep their previous values.
            r_quot       <= '0;
            r_rem        <= '0;
            r_err        <= 1'b1;
            r_resp_valid <= w_pick_oh;
          end else begin
            r_dividend <= w_sel_dividend;
            r_divisor  <= w_sel_divisor;
          end
        end
        ISSUE: r_div_in_valid <= 1'b1;
        WAIT: if (div_data_out_valid) begin
          r_quot       <= div_quotient;
          r_rem        <= div_remainder;
          r_err        <= div_error;
          r_resp_valid <= r_gnt_oh;
        end
        RESP: r_last <= r_gnt_idx;
        default: ;
      endcase
    end
  end

  assign req_if.req_ready      = r_req_ready;
  assign req_if.resp_valid     = r_resp_valid;
  assign req_if.resp_quotient  = r_quot;
  assign req_if.resp_remainder = r_rem;
  assign req_if.resp_error     = r_err;
  assign div_dividend          = r_dividend;
  assign div_divisor           = r_divisor;
  assign div_data_in_valid     = r_div_in_valid;
  assign arb_busy              = (r_state != IDLE);

endmodule

// File: tb/tb_div_arbiter.sv
module tb_div_arbiter;

  localparam int W       = 32;
  localparam int N       = 4;
  localparam int DIV_LAT = 4;
`ifdef DIV_ARB_ZERO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  div_arbiter_if #(.WIDTH(W), .NUM_REQ(N)) bus ();

  logic [W-1:0] div_dividend, div_divisor, div_quotient, div_remainder;
  logic         div_data_in_valid, div_data_out_valid, div_error, div_busy, arb_busy;
  logic         spur = 1'b0;

  div_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
    .clk                (clk),
    .rst                (rst),
    .req_if             (bus),
    .div_dividend       (div_dividend),
    .div_divisor        (div_divisor),
    .div_data_in_valid  (div_data_in_valid),
    .div_quotient       (div_quotient),
    .div_remainder      (div_remainder),
    .div_data_out_valid (div_data_out_valid),
    .div_error          (div_error),
    .div_busy           (div_busy),
    .arb_busy           (arb_busy)
  );

  // Behavioural multi-cycle divider, reset from the same rst.
  logic [W-1:0] m_a, m_b, m_q, m_r;
  logic         m_e, m_busy, m_ov;
  int           m_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_a <= '0; m_b <= '0; m_q <= '0; m_r <= '0;
      m_e <= 1'b0; m_busy <= 1'b0; m_ov <= 1'b0; m_cnt <= 0;
    end else begin
      m_ov <= 1'b0;
      if (m_busy) begin
        if (m_cnt == 1) begin
          m_busy <= 1'b0;
          m_ov   <= 1'b1;
          if (m_b == '0) begin
            m_q <= '0; m_r <= '0; m_e <= 1'b1;
          end else begin
            m_q <= m_a / m_b; m_r <= m_a % m_b; m_e <= 1'b0;
          end
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end else if (div_data_in_valid) begin
        m_a    <= div_dividend;
        m_b    <= div_divisor;
        m_busy <= 1'b1;
        m_cnt  <= DIV_LAT;
      end
    end
  end

  assign div_quotient       = m_q;
  assign div_remainder      = m_r;
  assign div_error          = m_e;
  assign div_busy           = m_busy;
  assign div_data_out_valid = m_ov | spur;

  typedef struct {
    int           idx;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         e;
  } exp_t;

  exp_t         sb[$];
  int           n_pass  = 0;
  int           n_total = 0;
  int           n_resp  = 0;
  int           n_start = 0;
  logic         prev_ov  = 1'b0;
  logic         prev_rdy = 1'b0;
  logic [N-1:0] hold = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One clock: sample at the falling edge, score responses, drop accepted requests.
  task automatic step();
    exp_t e;
    logic lat_ok;
    @(negedge clk);
    if (rst) begin
      prev_ov  = 1'b0;
      prev_rdy = 1'b0;
      return;
    end
    if (|bus.resp_valid) begin
      n_resp++;
      if (sb.size() == 0) begin
        chk("resp_unexpected", 64'(bus.resp_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("resp_owner", 64'(bus.resp_valid), 64'(1) << e.idx);
        chk("resp_quotient", 64'(bus.resp_quotient), 64'(e.q));
        chk("resp_remainder", 64'(bus.resp_remainder), 64'(e.r));
        chk("resp_error", 64'(bus.resp_error), 64'(e.e));
        lat_ok = prev_ov || (BYPASS && (bus.req_ready == bus.resp_valid));
        chk("resp_latency", 64'(lat_ok), 64'd1);
      end
    end
    if (div_data_in_valid) begin
      n_start++;
      chk("start_latency", 64'(prev_rdy), 64'd1);
    end
    prev_ov  = div_data_out_valid;
    prev_rdy = |bus.req_ready;
    for (int i = 0; i < N; i++)
      if (bus.req_ready[i] && !hold[i]) bus.req_valid[i] = 1'b0;
  endtask

  task automatic expect_resp(input int i, input logic [W-1:0] q, input logic [W-1:0] r, input logic e);
    exp_t x;
    x.idx = i; x.q = q; x.r = r; x.e = e;
    sb.push_back(x);
  endtask

  task automatic drive(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic hd);
    bus.req_dividend[i] = a;
    bus.req_divisor[i]  = b;
    hold[i]             = hd;
    bus.req_valid[i]    = 1'b1;
  endtask

  task automatic drain(input string tag, input int budget);
    for (int k = 0; k < budget && sb.size() != 0; k++) step();
    chk({"drain_", tag}, 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  initial begin
    int s0;
    int r0;
    bus.req_valid    = '0;
    bus.req_dividend = '0;
    bus.req_divisor  = '0;

    // Reset state
    rst = 1'b1;
    repeat (3) step();
    chk("rst_arb_busy",   64'(arb_busy), 64'd0);
    chk("rst_req_ready",  64'(bus.req_ready), 64'd0);
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_start",      64'(div_data_in_valid), 64'd0);
    chk("rst_dividend",   64'(div_dividend), 64'd0);
    chk("rst_divisor",    64'(div_divisor), 64'd0);
    chk("rst_quotient",   64'(bus.resp_quotient), 64'd0);
    chk("rst_error",      64'(bus.resp_error), 64'd0);
    rst = 1'b0;
    step();

    // Single request on requester 0
    expect_resp(0, 14, 2, 1'b0);
    drive(0, 100, 7, 1'b0);
    drain("single", 40);
    repeat (3) step();
    chk("bus_hold_quotient",  64'(bus.resp_quotient), 64'd14);
    chk("bus_hold_remainder", 64'(bus.resp_remainder), 64'd2);

    // All four together straight after reset: 0,1,2,3
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    step();
    expect_resp(0, 10, 0, 1'b0);
    expect_resp(1, 7, 7, 1'b0);
    expect_resp(2, 333, 1, 1'b0);
    expect_resp(3, 255, 255, 1'b0);
    drive(0, 50, 5, 1'b0);
    drive(1, 77, 10, 1'b0);
    drive(2, 1000, 3, 1'b0);
    drive(3, 65535, 256, 1'b0);
    drain("all_four", 120);

    // Divide by zero on requester 2
    s0 = n_start;
    expect_resp(2, 0, 0, 1'b1);
    drive(2, 1234, 0, 1'b0);
    drain("zero_div", 40);
    chk("zero_div_starts", 64'(n_start - s0), BYPASS ? 64'd0 : 64'd1);

    // Dividend smaller than divisor
    expect_resp(0, 0, 5, 1'b0);
    drive(0, 5, 9, 1'b0);
    drain("small", 40);

    // Requester 1 held, requester 3 requesting: 1,3,1,3
    expect_resp(1, 22, 2, 1'b0);
    expect_resp(3, 3, 2, 1'b0);
    expect_resp(1, 22, 2, 1'b0);
    expect_resp(3, 3, 2, 1'b0);
    drive(1, 90, 4, 1'b1);
    drive(3, 17, 5, 1'b1);
    for (int k = 0; k < 200 && sb.size() > 1; k++) step();
    hold = '0;
    bus.req_valid[1] = 1'b0;
    drain("alternate", 60);

    // Divider strobe while idle is ignored
    repeat (2) step();
    r0 = n_resp;
    spur = 1'b1;
    step();
    spur = 1'b0;
    repeat (3) step();
    chk("spurious_ignored", 64'(n_resp), 64'(r0));
    chk("idle_not_busy", 64'(arb_busy), 64'd0);

    // Reset during WAIT abandons the transaction
    s0 = n_start;
    drive(0, 4000, 3, 1'b0);
    for (int k = 0; k < 20 && n_start == s0; k++) step();
    chk("abandon_started", 64'(n_start - s0), 64'd1);
    step();
    chk("busy_in_wait", 64'(arb_busy), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_async_busy", 64'(arb_busy), 64'd0);
    chk("rst_async_resp", 64'(bus.resp_valid), 64'd0);
    repeat (2) step();
    rst = 1'b0;
    r0 = n_resp;
    repeat (DIV_LAT + 4) step();
    chk("abandon_no_resp", 64'(n_resp), 64'(r0));
    expect_resp(0, 30, 10, 1'b0);
    drive(0, 1000, 33, 1'b0);
    drain("after_reset", 40);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
